// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: 2-flop sync, debounce, press pulses and switch change strobe.
// Auto-repeat on masked buttons is built only when PANEL_AUTOREPEAT_EN is defined.
module panel_input_conditioner #(
  parameter int         DEBOUNCE_CYCLES     = 250000,
  parameter int         REPEAT_DELAY_CYCLES = 12500000,
  parameter int         REPEAT_RATE_CYCLES  = 2500000,
  parameter logic [5:0] REPEAT_MASK         = 6'b101010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] btn_raw,
  input  logic [7:0] sense_raw,
  output logic [5:0] btn_level,
  output logic [5:0] btn_press,
  output logic [7:0] sense_out,
  output logic       sense_changed
);

  localparam int NIN = 14;
  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_TERM = DW'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0] raw_all;
  logic [NIN-1:0] synced;
  logic [NIN-1:0] stable;
  logic [NIN-1:0] upd;

  assign raw_all = {sense_raw, btn_raw};

  for (genvar i = 0; i < NIN; i++) begin : g_in
    logic          s1;
    logic          s2;
    logic          lvl;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw_all[i];
        s2 <= s1;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_TERM) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    assign synced[i] = s2;
    assign stable[i] = lvl;
    // High in the cycle before the new level is registered.
    assign upd[i]    = (s2 != lvl) && (cnt == DB_TERM);
  end

  assign btn_level = stable[5:0];
  assign sense_out = stable[13:6];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sense_changed <= 1'b0;
    end else begin
      sense_changed <= |upd[13:6];
    end
  end

`ifdef PANEL_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] DELAY_TERM = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_TERM  = RW'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK, 32'(REPEAT_DELAY_CYCLES), 32'(REPEAT_RATE_CYCLES)};
`endif

  for (genvar i = 0; i < 6; i++) begin : g_btn
    logic press_q;

`ifdef PANEL_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_t    state;
      logic [RW-1:0] cnt;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          state   <= IDLE;
          cnt     <= '0;
          press_q <= 1'b0;
        end else begin
          press_q <= upd[i] & synced[i];
          // A release wins over a coincident terminal count: no pulse that cycle.
          if (upd[i] && !synced[i]) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            case (state)
              IDLE: begin
                if (upd[i] && synced[i]) begin
                  state <= DELAY;
                  cnt   <= '0;
                end
              end
              DELAY: begin
                if (cnt == DELAY_TERM) begin
                  press_q <= 1'b1;
                  state   <= REPEAT;
                  cnt     <= '0;
                end else begin
                  cnt <= cnt + RW'(1);
                end
              end
              REPEAT: begin
                if (cnt == RATE_TERM) begin
                  press_q <= 1'b1;
                  cnt     <= '0;
                end else begin
                  cnt <= cnt + RW'(1);
                end
              end
              default: begin
                state <= IDLE;
                cnt   <= '0;
              end
            endcase
          end
        end
      end
    end else begin : g_norep
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          press_q <= 1'b0;
        end else begin
          press_q <= upd[i] & synced[i];
        end
      end
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        press_q <= 1'b0;
      end else begin
        press_q <= upd[i] & synced[i];
      end
    end
`endif

    assign btn_press[i] = press_q;
  end

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Bench for panel_input_conditioner: vector table, corner sequences, random traffic vs reference model.
module tb_panel_input_conditioner;

  localparam int         D    = 4;
  localparam int         RD   = 20;
  localparam int         RR   = 8;
  localparam logic [5:0] MASK = 6'b101010;
`ifdef PANEL_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] btn_raw;
  logic [7:0] sense_raw;
  logic [5:0] btn_level;
  logic [5:0] btn_press;
  logic [7:0] sense_out;
  logic       sense_changed;

  int tests = 0;
  int fails = 0;

  panel_input_conditioner #(
    .DEBOUNCE_CYCLES    (D),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR),
    .REPEAT_MASK        (MASK)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .btn_raw      (btn_raw),
    .sense_raw    (sense_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .sense_out    (sense_out),
    .sense_changed(sense_changed)
  );

  always #5 clk = ~clk;

  // Reference model: an input is accepted after D consecutive edges on which its
  // two-cycle-delayed raw sample disagrees with the accepted level.
  logic [13:0] m_stable;
  int          m_run[14];
  logic [13:0] dq[$];
  int          ecount;
  int          press_at[6];
  bit          held[6];
  logic [5:0]  m_press;
  logic        m_chg;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    m_stable = '0;
    for (int i = 0; i < 14; i++) m_run[i] = 0;
    for (int i = 0; i < 6; i++) held[i] = 1'b0;
    m_press = '0;
    m_chg   = 1'b0;
  endtask

  task automatic model_step(input logic [13:0] raw);
    logic [13:0] d;
    logic [13:0] upd;
    int          n;
    ecount++;
    dq.push_back(raw);
    d   = (dq.size() > 2) ? dq.pop_front() : 14'h0;
    upd = '0;
    for (int i = 0; i < 14; i++) begin
      if (d[i] != m_stable[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == D) begin
        m_stable[i] = d[i];
        m_run[i]    = 0;
        upd[i]      = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      m_press[i] = 1'b0;
      if (upd[i] && d[i]) begin
        held[i]     = 1'b1;
        press_at[i] = ecount;
        m_press[i]  = 1'b1;
      end else if (upd[i]) begin
        held[i] = 1'b0;
      end else if (REP_EN && MASK[i] && held[i]) begin
        n = ecount - press_at[i];
        if (n == RD || (n > RD && (n - RD) % RR == 0)) m_press[i] = 1'b1;
      end
    end
    m_chg = |upd[13:6];
  endtask

  // Called at a falling edge: drive inputs, advance the model, check after the next rising edge.
  task automatic tick(input logic [5:0] b, input logic [7:0] s);
    btn_raw   = b;
    sense_raw = s;
    if (!resetn) model_reset();
    else model_step({s, b});
    @(negedge clk);
    chk("m_level", int'(btn_level), int'(m_stable[5:0]));
    chk("m_press", int'(btn_press), int'(m_press));
    chk("m_sense", int'(sense_out), int'(m_stable[13:6]));
    chk("m_chg", int'(sense_changed), int'(m_chg));
  endtask

  typedef struct {
    logic [5:0] btn;
    logic [7:0] sense;
    int         cycles;
    logic [5:0] lvl;
    logic [7:0] sout;
    int         npress;
    int         nchg;
  } vec_t;

  vec_t vt[8];

  initial begin
    int np, nc;
    int pulses[$];
    int exp_q[$];
    logic [5:0] rb;
    logic [7:0] rs;
    int r;

    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int np, nc;
    int pulses[$];
    int exp_q[$];
    logic [5:0] rb;
    logic [7:0] rs;
    int r;

    vt[0] = '{6'b000100, 8'h00, 10, 6'b000100, 8'h00, 1, 0};
    vt[1] = '{6'b000000, 8'h00, 10, 6'b000000, 8'h00, 0, 0};
    vt[2] = '{6'b000000, 8'hA5, 10, 6'b000000, 8'hA5, 0, 1};
    vt[3] = '{6'b000000, 8'hA4,  2, 6'b000000, 8'hA5, 0, 0};
    vt[4] = '{6'b000000, 8'hA5, 10, 6'b000000, 8'hA5, 0, 0};
    vt[5] = '{6'b100001, 8'hA5, 10, 6'b100001, 8'hA5, 2, 0};
    vt[6] = '{6'b000000, 8'hA5, 10, 6'b000000, 8'hA5, 0, 0};
    vt[7] = '{6'b000000, 8'h00, 10, 6'b000000, 8'h00, 0, 1};

    ecount    = 0;
    resetn    = 1'b0;
    btn_raw   = '0;
    sense_raw = '0;
    model_reset();
    @(negedge clk);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(btn_press), 0);
    chk("rst_sense", int'(sense_out), 0);
    chk("rst_chg", int'(sense_changed), 0);
    tick(6'h0, 8'h0);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) tick(6'h0, 8'h0);

    for (int v = 0; v < 8; v++) begin
      np = 0;
      nc = 0;
      for (int c = 0; c < vt[v].cycles; c++) begin
        tick(vt[v].btn, vt[v].sense);
        np += $countones(btn_press);
        nc += int'(sense_changed);
      end
      chk($sformatf("vec%0d_level", v), int'(btn_level), int'(vt[v].lvl));
      chk($sformatf("vec%0d_sense", v), int'(sense_out), int'(vt[v].sout));
      chk($sformatf("vec%0d_npress", v), np, vt[v].npress);
      chk($sformatf("vec%0d_nchg", v), nc, vt[v].nchg);
    end

    // Clean press on an unmasked button: level exactly 1+D edges after capture.
    for (int c = 1; c <= 5; c++) begin
      tick(6'b000100, 8'h00);
      chk($sformatf("clean_lvl_early%0d", c), int'(btn_level[2]), 0);
    end
    tick(6'b000100, 8'h00);
    chk("clean_lvl", int'(btn_level[2]), 1);
    chk("clean_press", int'(btn_press), int'(6'b000100));
    np = 0;
    for (int c = 0; c < 30; c++) begin
      tick(6'b000100, 8'h00);
      np += $countones(btn_press);
    end
    chk("clean_no_repeat", np, 0);
    for (int c = 0; c < 10; c++) tick(6'h0, 8'h00);

    // Glitch: 3 high, 1 low, 3 high.
    np = 0;
    for (int c = 0; c < 15; c++) begin
      tick((c < 3 || (c >= 4 && c < 7)) ? 6'b000010 : 6'b000000, 8'h00);
      np += $countones(btn_press) + int'(btn_level[1]);
    end
    chk("glitch_reject", np, 0);

    // Auto-repeat on step, released so the fall lands on the would-be +60 pulse.
    for (int c = 1; c <= 6; c++) tick(6'b000010, 8'h00);
    chk("rep_first_press", int'(btn_press), int'(6'b000010));
    pulses.delete();
    for (int n = 1; n <= 70; n++) begin
      tick((n < 55) ? 6'b000010 : 6'b000000, 8'h00);
      if (btn_press[1]) pulses.push_back(n);
      if (n == 59) chk("rep_lvl_before_rel", int'(btn_level[1]), 1);
      if (n == 60) chk("rep_lvl_after_rel", int'(btn_level[1]), 0);
    end
    exp_q.delete();
    if (REP_EN) exp_q = '{20, 28, 36, 44, 52};
    chk("rep_npulses", pulses.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < pulses.size(); k++)
      chk($sformatf("rep_pulse%0d", k), pulses[k], exp_q[k]);

    // Reset while in REPEAT, button held through and after reset.
    for (int c = 1; c <= 6; c++) tick(6'b001000, 8'h00);
    chk("rst_seq_press", int'(btn_press), int'(6'b001000));
    for (int c = 0; c < 25; c++) tick(6'b001000, 8'h00);
    resetn = 1'b0;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_press", int'(btn_press), 0);
    chk("midrst_sense", int'(sense_out), 0);
    chk("midrst_chg", int'(sense_changed), 0);
    for (int c = 0; c < 3; c++) tick(6'b001000, 8'h00);
    resetn = 1'b1;
    pulses.delete();
    for (int n = 1; n <= 30; n++) begin
      tick(6'b001000, 8'h00);
      if (btn_press[3]) pulses.push_back(n);
    end
    exp_q.delete();
    if (REP_EN) exp_q = '{6, 26};
    else exp_q = '{6};
    chk("postrst_npulses", pulses.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < pulses.size(); k++)
      chk($sformatf("postrst_pulse%0d", k), pulses[k], exp_q[k]);
    for (int c = 0; c < 10; c++) tick(6'h0, 8'h00);

    // Random traffic with occasional resets.
    rb = '0;
    rs = '0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 15);
      if (r < 2) rb = rb ^ (6'b000001 << $urandom_range(0, 5));
      else if (r < 4) rs = rs ^ (8'h01 << $urandom_range(0, 7));
      resetn = ($urandom_range(0, 799) != 0);
      tick(rb, rs);
    end
    resetn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
